// File: rtl/cic_decimator.sv
// Third-order CIC (sinc^3) decimator: three running integrators at the input rate,
// three first-difference combs at the decimated rate, full-precision output.
module cic_decimator #(
  parameter  int DECIMATION_LOG2 = 6,
  parameter  int N_BITS_IN       = 9,
  localparam int N_BITS_OUT      = N_BITS_IN + 3 * DECIMATION_LOG2
) (
  input  logic                       CLK_3M,
  input  logic                       reset,
  input  logic [N_BITS_IN-1:0]       channel_input,
  input  logic                       in_valid,
  output logic [N_BITS_OUT-1:0]      data_out,
  output logic                       data_valid,
  output logic [DECIMATION_LOG2-1:0] frame_phase
);

  localparam logic [DECIMATION_LOG2-1:0] PHASE_LAST = '1;

  logic [N_BITS_OUT-1:0]      x_ext;
  logic [N_BITS_OUT-1:0]      i1_q, i2_q, i3_q, i1_d, i2_d, i3_d;
  logic [N_BITS_OUT-1:0]      d1_q, d2_q, d3_q, d1_d, d2_d, d3_d;
  logic [N_BITS_OUT-1:0]      c1, c2, c3;
  logic [N_BITS_OUT-1:0]      data_out_q, data_out_d;
  logic                       data_valid_q, data_valid_d;
  logic                       tick_q, tick_d;
  logic [DECIMATION_LOG2-1:0] phase_q, phase_d;

  assign x_ext = {{(3 * DECIMATION_LOG2){channel_input[N_BITS_IN-1]}}, channel_input};

  // Integrators: each stage adds the previous stage's old value, so the chain
  // is pipelined. Wrap-around is intentional; the combs cancel it exactly.
  always_comb begin
    i1_d    = i1_q;
    i2_d    = i2_q;
    i3_d    = i3_q;
    phase_d = phase_q;
    tick_d  = in_valid && (phase_q == PHASE_LAST);
    if (in_valid) begin
      i1_d    = i1_q + x_ext;
      i2_d    = i2_q + i1_q;
      i3_d    = i3_q + i2_q;
      phase_d = phase_q + 1'b1;
    end
  end

  // Combs evaluate on the cycle after the frame's last sample, regardless of in_valid.
  always_comb begin
    c1           = i3_q - d1_q;
    c2           = c1 - d2_q;
    c3           = c2 - d3_q;
    d1_d         = d1_q;
    d2_d         = d2_q;
    d3_d         = d3_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    if (tick_q) begin
      d1_d         = i3_q;
      d2_d         = c1;
      d3_d         = c2;
      data_out_d   = c3;
      data_valid_d = 1'b1;
    end
  end

  always_ff @(posedge CLK_3M) begin
    if (!reset) begin
      i1_q         <= '0;
      i2_q         <= '0;
      i3_q         <= '0;
      d1_q         <= '0;
      d2_q         <= '0;
      d3_q         <= '0;
      tick_q       <= 1'b0;
      phase_q      <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
    end else begin
      i1_q         <= i1_d;
      i2_q         <= i2_d;
      i3_q         <= i3_d;
      d1_q         <= d1_d;
      d2_q         <= d2_d;
      d3_q         <= d3_d;
      tick_q       <= tick_d;
      phase_q      <= phase_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
    end
  end

  assign data_out    = data_out_q;
  assign data_valid  = data_valid_q;
  assign frame_phase = phase_q;

endmodule
